// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, RAM handshake state, arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating up-counter with synchronous clear; tracks consecutive data grants.
module arb_streak_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [CW-1:0] count_q, count_d;

  assign full  = (count_q == CW'(MAX));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !full) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access.
// Data has priority; a streak counter forces an instruction grant after MAX_DSTREAK data grants.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ramerr
);

  localparam int unsigned CW = $clog2(MAX_DSTREAK + 1);

  arb_state_t state_q, state_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  logic       wr_q, wr_d;
  word_t      iload_q, iload_d;
  word_t      dload_q, dload_d;
  logic       ihit_q, ihit_d;
  logic       dhit_q, dhit_d;
  logic       ramerr_q, ramerr_d;

  logic          streak_inc, streak_clr, streak_full;
  logic [CW-1:0] streak_count;
  ramstate_t     rs;
  logic          active;

  assign rs = ramstate_t'(ramstate);

  arb_streak_counter #(
    .MAX (MAX_DSTREAK),
    .CW  (CW)
  ) u_streak (
    .clk   (CLK),
    .rst   (RST),
    .inc   (streak_inc),
    .clr   (streak_clr),
    .count (streak_count),
    .full  (streak_full)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    store_d    = store_q;
    wr_d       = wr_q;
    iload_d    = iload_q;
    dload_d    = dload_q;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    ramerr_d   = 1'b0;
    streak_inc = 1'b0;
    streak_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if ((dREN || dWEN) && !(iREN && streak_full)) begin
          state_d = DACC;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          // Streak only grows while an instruction fetch is actually waiting.
          if (iREN) streak_inc = 1'b1;
          else      streak_clr = 1'b1;
        end else if (iREN) begin
          state_d    = IACC;
          addr_d     = iaddr;
          store_d    = '0;
          wr_d       = 1'b0;
          streak_clr = 1'b1;
        end
      end
      IACC, DACC: begin
        if (rs == ACCESS) begin
          state_d = DONE;
          if (state_q == IACC) begin
            iload_d = ramload;
            ihit_d  = 1'b1;
          end else begin
            if (!wr_q) dload_d = ramload;
            dhit_d = 1'b1;
          end
        end else if (rs == ERROR) begin
          state_d  = IDLE;
          ramerr_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      iload_q  <= '0;
      dload_q  <= '0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      ramerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
      ihit_q   <= ihit_d;
      dhit_q   <= dhit_d;
      ramerr_q <= ramerr_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign active   = (state_q == IACC) || (state_q == DACC);
  assign ramREN   = (state_q == IACC) || ((state_q == DACC) && !wr_q);
  assign ramWEN   = (state_q == DACC) && wr_q;
  assign ramaddr  = active ? addr_q  : '0;
  assign ramstore = active ? store_q : '0;

  assign ihit   = ihit_q;
  assign dhit   = dhit_q;
  assign ramerr = ramerr_q;
  assign iload  = iload_q;
  assign dload  = dload_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level reference model plus RAM responder.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int MAX = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit, ramREN, ramWEN, ramerr;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  int checks = 0;
  int errors = 0;

  // reference model state
  int    streak = 0;
  word_t exp_iload = '0;
  word_t exp_dload = '0;

  always #5 CLK = ~CLK;

  ram_arbiter #(.MAX_DSTREAK(MAX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ramREN"}, {31'd0, ramREN}, 32'd0);
    chk({tag, ".ramWEN"}, {31'd0, ramWEN}, 32'd0);
    chk({tag, ".ihit"},   {31'd0, ihit},   32'd0);
    chk({tag, ".dhit"},   {31'd0, dhit},   32'd0);
  endtask

  // One arbitration round, entered and left while the arbiter is idle.
  task automatic txn(input bit ir, input bit dr, input bit dw,
                     input word_t ia, input word_t da, input word_t ds,
                     input int nbusy, input bit err, input word_t rd);
    bit    gd, gi, ewr;
    word_t ea, es;
    iREN = ir; dREN = dr; dWEN = dw;
    iaddr = ia; daddr = da; dstore = ds;
    ramstate = FREE;
    gd = (dr || dw) && !(ir && streak == MAX);
    gi = !gd && ir;
    ea = '0; es = '0; ewr = 1'b0;
    if (gd) begin
      streak = ir ? ((streak < MAX) ? streak + 1 : MAX) : 0;
      ea = da; es = ds; ewr = dw;
    end else if (gi) begin
      streak = 0;
      ea = ia;
    end
    @(posedge CLK); #1;
    if (!gd && !gi) begin
      chk_quiet("idle");
      chk("idle.ramaddr", ramaddr, 32'd0);
      chk("idle.ramerr", {31'd0, ramerr}, 32'd0);
      return;
    end
    // Requests changing mid-access must not disturb the latched one.
    iREN = 1'($urandom); dREN = 1'($urandom); dWEN = 1'($urandom);
    iaddr = $urandom; daddr = $urandom; dstore = $urandom;
    for (int k = 0; k <= nbusy; k++) begin
      chk("acc.ramREN",   {31'd0, ramREN}, {31'd0, gi || !ewr});
      chk("acc.ramWEN",   {31'd0, ramWEN}, {31'd0, gd && ewr});
      chk("acc.ramaddr",  ramaddr,  ea);
      chk("acc.ramstore", ramstore, es);
      chk("acc.hits",     {30'd0, ihit, dhit}, 32'd0);
      if (k < nbusy) begin
        ramstate = ($urandom_range(0, 1) != 0) ? BUSY : FREE;
        ramload  = $urandom;
      end else begin
        ramstate = err ? ERROR : ACCESS;
        ramload  = rd;
      end
      @(posedge CLK); #1;
    end
    ramstate = FREE;
    ramload  = $urandom;
    if (err) begin
      chk("err.ramerr", {31'd0, ramerr}, 32'd1);
      chk_quiet("err");
      return;
    end
    if (gi) exp_iload = rd;
    else if (!ewr) exp_dload = rd;
    chk("hit.ihit",   {31'd0, ihit},   {31'd0, gi});
    chk("hit.dhit",   {31'd0, dhit},   {31'd0, gd});
    chk("hit.ramerr", {31'd0, ramerr}, 32'd0);
    chk("hit.ramREN", {31'd0, ramREN}, 32'd0);
    chk("hit.ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("hit.iload",  iload, exp_iload);
    chk("hit.dload",  dload, exp_dload);
    @(posedge CLK); #1;
    chk_quiet("guard");
    chk("guard.iload", iload, exp_iload);
    chk("guard.dload", dload, exp_dload);
  endtask

  initial begin
    RST = 1'b1;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
    #12;
    chk_quiet("rst");
    chk("rst.ramerr",   {31'd0, ramerr}, 32'd0);
    chk("rst.iload",    iload,    32'd0);
    chk("rst.dload",    dload,    32'd0);
    chk("rst.ramaddr",  ramaddr,  32'd0);
    chk("rst.ramstore", ramstore, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // single fetch with two BUSY cycles
    txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 2, 0, 32'h8C22_0004);
    // data priority over a simultaneous fetch, then the fetch
    txn(1, 1, 0, 32'h44, 32'h100, 32'h0, 1, 0, 32'hDEAD_BEEF);
    txn(1, 0, 0, 32'h44, 32'h0, 32'h0, 0, 0, 32'h0000_1111);
    // starvation bound: iREN and dWEN held
    for (int n = 0; n < 11; n++)
      txn(1, 0, 1, 32'h80 + n * 4, 32'h300 + n * 4, $urandom, n % 3, 0, $urandom);
    // write with dREN also high; dload must stay
    txn(0, 1, 1, 32'h0, 32'h200, 32'h1234_5678, 0, 0, 32'hFFFF_FFFF);
    // error during data read, then retry
    txn(0, 1, 0, 32'h0, 32'h180, 32'h0, 1, 1, 32'hBAD0_BAD0);
    txn(0, 1, 0, 32'h0, 32'h180, 32'h0, 0, 0, 32'h5555_AAAA);
    txn(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);

    // randomized rounds
    for (int n = 0; n < 60; n++)
      txn(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom);

    // reset in the middle of an instruction access
    iREN = 1; dREN = 0; dWEN = 0; iaddr = 32'h600;
    @(posedge CLK); #1;
    chk("mid.ramREN", {31'd0, ramREN}, 32'd1);
    ramstate = BUSY;
    #2 RST = 1'b1;
    #1;
    chk("mid.rst.ramREN",  {31'd0, ramREN}, 32'd0);
    chk("mid.rst.ramaddr", ramaddr, 32'd0);
    iREN = 0;
    ramstate = ACCESS;
    @(posedge CLK); #1;
    chk("mid.rst.ihit", {31'd0, ihit}, 32'd0);
    RST = 1'b0;
    ramstate = FREE;
    streak = 0; exp_iload = '0; exp_dload = '0;
    chk("mid.rst.iload", iload, 32'd0);
    txn(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
    txn(1, 0, 0, 32'h604, 32'h0, 32'h0, 1, 0, 32'hC0DE_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
